// File: rtl/pa_risc_pkg.sv
// Shared fetch-stage types and constants.
//   fetch_state_t    : FETCH / HOLD / DRAIN fetch-control states
//   NOP_ENC          : bubble encoding used for squashed or empty IF/ID slots
//   PC_INCR          : sequential PC step in bytes
//   WORD_ALIGN_MASK  : clears the byte-offset bits of an address
package pa_risc_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [XLEN-1:0] NOP_ENC         = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INCR         = 32'd4;
    localparam logic [XLEN-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_npc_reg.sv
// PC / nPC register pair with sequential advance and branch redirect.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   advance_i         step PC<=nPC, nPC<=nPC+4
//   redirect_i        load PC<=target_i, nPC<=target_i+4 (wins over advance)
//   target_i          word-aligned redirect address
//   pc_o, npc_o       current PC and nPC
//   pc_next_c         PC value after this edge (combinational)
module pc_npc_reg
    import pa_risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] npc_o,
    output logic [XLEN-1:0] pc_next_c
);

    logic [XLEN-1:0] pc_q, npc_q;
    logic [XLEN-1:0] npc_d;

    // Redirect outranks advance; arithmetic wraps modulo 2^32.
    always_comb begin
        pc_next_c = pc_q;
        npc_d     = npc_q;
        if (redirect_i) begin
            pc_next_c = target_i;
            npc_d     = target_i + PC_INCR;
        end else if (advance_i) begin
            pc_next_c = npc_q;
            npc_d     = npc_q + PC_INCR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            npc_q <= RESET_PC + PC_INCR;
        end else begin
            pc_q  <= pc_next_c;
            npc_q <= npc_d;
        end
    end

    assign pc_o  = pc_q;
    assign npc_o = npc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// One outstanding instruction-memory request, hazard stall (le), branch
// redirect into a DRAIN state for in-flight requests, and IF/ID nullify.
// Optional build macro FETCH_STATS_EN adds fetch_cnt / stall_cnt outputs.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   le                             decode load enable (0 = stalled)
//   branch_taken, branch_target    redirect pulse and address from EX
//   nullify                        turn current IF/ID into a bubble
//   imem_req/addr, imem_rvalid/rdata  instruction-memory handshake
//   ifid_instr/pc/valid            IF/ID register contents
//   fetch_cnt, stall_cnt           statistics (FETCH_STATS_EN only)
module if_fetch_stage
    import pa_risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
    input  logic        clk,
    input  logic        reset,
`ifdef FETCH_STATS_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
`endif
    input  logic        le,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        nullify,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid
);

    fetch_state_t    state_q;
    logic            imem_req_q;
    logic [XLEN-1:0] imem_addr_q;
    logic [XLEN-1:0] hold_q;
    logic [XLEN-1:0] ifid_instr_q, ifid_pc_q;
    logic            ifid_valid_q;

    logic            rv_c, load_c;
    logic [XLEN-1:0] load_data_c, target_c;
    logic [XLEN-1:0] pc_c, npc_c, pc_next_c;

    // A response only counts while our request is being driven; this also
    // drops a stray response in the first cycle after reset.
    always_comb begin
        rv_c        = imem_rvalid & imem_req_q;
        target_c    = branch_target & WORD_ALIGN_MASK;
        load_c      = 1'b0;
        load_data_c = imem_rdata;
        case (state_q)
            FETCH:   load_c = rv_c & le & ~branch_taken;
            HOLD: begin
                load_c      = le & ~branch_taken;
                load_data_c = hold_q;
            end
            default: load_c = 1'b0;
        endcase
    end

    pc_npc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk       (clk),
        .reset     (reset),
        .advance_i (load_c),
        .redirect_i(branch_taken),
        .target_i  (target_c),
        .pc_o      (pc_c),
        .npc_o     (npc_c),
        .pc_next_c (pc_next_c)
    );

    // Fetch FSM, request outputs and hold buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            hold_q      <= NOP_INSTR;
        end else begin
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_next_c;
            case (state_q)
                FETCH: begin
                    if (branch_taken) begin
                        if (!rv_c) begin
                            // In-flight request must complete before retargeting.
                            state_q     <= DRAIN;
                            imem_addr_q <= imem_addr_q;
                        end
                    end else if (rv_c && !le) begin
                        state_q    <= HOLD;
                        hold_q     <= imem_rdata;
                        imem_req_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (branch_taken || le) state_q <= FETCH;
                    else                    imem_req_q <= 1'b0;
                end
                DRAIN: begin
                    if (rv_c) state_q     <= FETCH;
                    else      imem_addr_q <= imem_addr_q;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    // IF/ID register: a load beats nullify; a redirect leaves the delay slot alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else if (load_c) begin
            ifid_instr_q <= load_data_c;
            ifid_pc_q    <= pc_c;
            ifid_valid_q <= 1'b1;
        end else if (nullify || (le && !branch_taken)) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Delivered instructions and cycles spent waiting on memory or decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (load_c) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (state_q == HOLD || (state_q == FETCH && !rv_c))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; memory responses are driven by hand.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        le = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        nullify = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    if_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
`ifdef FETCH_STATS_EN
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt),
`endif
        .le           (le),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .nullify      (nullify),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_valid   (ifid_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return 32'hC000_0000 ^ a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] i, input logic [31:0] p,
                            input logic v);
        chk({tag, ".instr"}, ifid_instr, i);
        chk({tag, ".pc"}, ifid_pc, p);
        chk({tag, ".valid"}, 32'(ifid_valid), 32'(v));
    endtask

    // Reset, then step into the first request cycle (req=1, addr=RESET_PC).
    task automatic do_reset();
        reset = 1'b1;
        imem_rvalid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One request with 1-cycle memory latency, delivered with le=1.
    task automatic fetch_one(input logic [31:0] a);
        le = 1'b1;
        imem_rvalid = 1'b0;
        tick();
        chk("wait.addr", imem_addr, a);
        chk("wait.req", 32'(imem_req), 32'd1);
        imem_rvalid = 1'b1;
        imem_rdata  = ins(a);
        tick();
        imem_rvalid = 1'b0;
        chk_ifid("deliver", ins(a), a, 1'b1);
        chk("next.addr", imem_addr, a + 32'd4);
    endtask

    initial begin
        // Reset values; stray response in first post-reset cycle ignored
        tick();
        tick();
        chk("rst.req", 32'(imem_req), 32'd0);
        chk("rst.addr", imem_addr, 32'h0);
        chk_ifid("rst", NOP, 32'h0, 1'b0);
        reset = 1'b0;
        le = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = JUNK;
        tick();
        chk("post.req", 32'(imem_req), 32'd1);
        chk("post.addr", imem_addr, 32'h0);
        chk_ifid("post", NOP, 32'h0, 1'b0);

        // Sequential fetch
        fetch_one(32'h0);
        fetch_one(32'h4);
        fetch_one(32'h8);
        fetch_one(32'hC);

        // Decode stall on delivery of addr 8 -> HOLD
        do_reset();
        fetch_one(32'h0);
        fetch_one(32'h4);
        le = 1'b0;
        tick();
        chk_ifid("s2.wait", ins(32'h4), 32'h4, 1'b1);
        imem_rvalid = 1'b1;
        imem_rdata  = ins(32'h8);
        tick();
        imem_rvalid = 1'b0;
        chk("s2.hold.req", 32'(imem_req), 32'd0);
        chk_ifid("s2.hold", ins(32'h4), 32'h4, 1'b1);
        tick();
        chk("s2.hold2.req", 32'(imem_req), 32'd0);
        chk_ifid("s2.hold2", ins(32'h4), 32'h4, 1'b1);
        le = 1'b1;
        tick();
        chk_ifid("s2.release", ins(32'h8), 32'h8, 1'b1);
        chk("s2.release.req", 32'(imem_req), 32'd1);
        chk("s2.release.addr", imem_addr, 32'hC);
        fetch_one(32'hC);
`ifdef FETCH_STATS_EN
        chk("s2.fetch_cnt", fetch_cnt, 32'd4);
`endif

        // Redirect while addr 0x10 waits on a 3-cycle response -> DRAIN
        le = 1'b0;
        tick();
        le = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        le = 1'b0;
        chk_ifid("s3.slot", ins(32'hC), 32'hC, 1'b1);
        chk("s3.drain.addr", imem_addr, 32'h10);
        chk("s3.drain.req", 32'(imem_req), 32'd1);
        tick();
        chk("s3.drain2.addr", imem_addr, 32'h10);
        imem_rvalid = 1'b1;
        imem_rdata  = ins(32'h10);
        tick();
        imem_rvalid = 1'b0;
        chk_ifid("s3.dropped", ins(32'hC), 32'hC, 1'b1);
        chk("s3.retarget", imem_addr, 32'h100);
        fetch_one(32'h100);

        // Nullify alone, then nullify together with a delivery
        le = 1'b0;
        nullify = 1'b1;
        tick();
        chk_ifid("s4.null", NOP, 32'h100, 1'b0);
        le = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = ins(32'h104);
        tick();
        imem_rvalid = 1'b0;
        nullify = 1'b0;
        chk_ifid("s4.loadwins", ins(32'h104), 32'h104, 1'b1);

        // Redirect in HOLD drops the buffer
        le = 1'b0;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = ins(32'h108);
        tick();
        imem_rvalid = 1'b0;
        chk("s5.hold.req", 32'(imem_req), 32'd0);
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        chk("s5.redir.addr", imem_addr, 32'h200);
        chk("s5.redir.req", 32'(imem_req), 32'd1);
        chk_ifid("s5.slot", ins(32'h104), 32'h104, 1'b1);
        fetch_one(32'h200);

        // Redirect coinciding with a response in FETCH: data discarded
        le = 1'b0;
        tick();
        le = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = ins(32'h204);
        branch_taken  = 1'b1;
        branch_target = 32'h300;
        tick();
        imem_rvalid  = 1'b0;
        branch_taken = 1'b0;
        chk("s5b.addr", imem_addr, 32'h300);
        chk_ifid("s5b.slot", ins(32'h200), 32'h200, 1'b1);

        // Reset mid-request: response right after reset ignored
        le = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("s5c.rst.req", 32'(imem_req), 32'd0);
        chk("s5c.rst.addr", imem_addr, 32'h0);
        chk_ifid("s5c.rst", NOP, 32'h0, 1'b0);
        reset = 1'b0;
        le = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = ins(32'h300);
        tick();
        chk_ifid("s5c.ignored", NOP, 32'h0, 1'b0);
        chk("s5c.addr", imem_addr, 32'h0);
        fetch_one(32'h0);

        // PC wraps from 0xFFFF_FFFC to 0
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        imem_rvalid  = 1'b1;
        imem_rdata   = JUNK;
        tick();
        imem_rvalid = 1'b0;
        chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC);
        chk("wrap.zero", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
